// File: rtl/cnt_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cnt_chk_pkg
//  Brief    : Shared types and constants for the counter output checker.
//  Revision : 1.0  initial release
// ============================================================================
package cnt_chk_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } state_t;

endpackage : cnt_chk_pkg
`default_nettype wire

// File: rtl/cnt_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cnt_sample_fifo
//  Brief    : Synchronous sample FIFO with wrap-bit pointers and a registered
//             head (valid/data) that holds its last value when empty.
//  Revision : 1.0  initial release
// ============================================================================
module cnt_sample_fifo
    import cnt_chk_pkg::*;
#(
    parameter int W     = CNT_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         drop
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]  r_wr;
    logic [c_aw:0]  r_rd;
    logic [c_aw:0]  w_wr_nxt;
    logic [c_aw:0]  w_rd_nxt;
    logic [W-1:0]   r_mem [DEPTH];
    logic           r_valid;
    logic [W-1:0]   r_data;
    logic           w_full;
    logic           w_pop;
    logic           w_push_acc;
    logic [W-1:0]   w_head_nxt;

    assign w_full     = (r_wr[c_aw] != r_rd[c_aw]) && (r_wr[c_aw-1:0] == r_rd[c_aw-1:0]);
    assign w_pop      = pop_ready & r_valid;
    assign w_push_acc = push & (~w_full | w_pop);
    assign drop       = push & w_full & ~w_pop;
    assign w_wr_nxt   = r_wr + {{c_aw{1'b0}}, w_push_acc};
    assign w_rd_nxt   = r_rd + {{c_aw{1'b0}}, w_pop};

    // The new head bypasses the array when it is the entry written this edge.
    assign w_head_nxt = (w_push_acc && (w_rd_nxt[c_aw-1:0] == r_wr[c_aw-1:0]))
                        ? din : r_mem[w_rd_nxt[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr[c_aw-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_wr    <= w_wr_nxt;
            r_rd    <= w_rd_nxt;
            r_valid <= (w_wr_nxt != w_rd_nxt);
            if (w_wr_nxt != w_rd_nxt) begin
                r_data <= w_head_nxt;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule : cnt_sample_fifo
`default_nettype wire

// File: rtl/cnt_out_checker.sv
`default_nettype none
// ============================================================================
//  Module   : cnt_out_checker
//  Brief    : Shadows an upstream load/enable counter, flags divergence of its
//             output, queues post-increment samples and counts wrap-arounds.
//  Revision : 1.0  initial release
// ============================================================================
module cnt_out_checker
    import cnt_chk_pkg::*;
#(
    parameter int W     = CNT_W,
    parameter int DEPTH = 4,
    parameter int WCW   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ld,
    input  logic [W-1:0]   ld_val,
    input  logic           en,
    input  logic [W-1:0]   cnt_out,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           mismatch,
    output logic           overflow,
    output logic [WCW-1:0] wrap_cnt,
    output logic [1:0]     state
);

    localparam logic [W-1:0] c_cnt_max = {W{1'b1}};

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_shadow;
    logic [W-1:0]   w_shadow_nxt;
    logic           r_en_d;
    logic           r_mismatch;
    logic           w_mismatch_nxt;
    logic           r_overflow;
    logic [WCW-1:0] r_wrap_cnt;
    logic           w_active;
    logic           w_en_acc;
    logic           w_push;
    logic           w_drop;
    logic           w_wrap_inc;

    assign w_active   = (r_state != IDLE);
    assign w_en_acc   = en & ~ld & w_active;
    // cnt_out is sampled one cycle after the accepted enable, once it has settled.
    assign w_push     = r_en_d & w_active & ~ld;
    assign w_wrap_inc = w_en_acc && (r_shadow == c_cnt_max) && (r_wrap_cnt != {WCW{1'b1}});

    always_comb begin
        w_state_nxt    = r_state;
        w_mismatch_nxt = r_mismatch;
        w_shadow_nxt   = r_shadow;
        if (ld) begin
            w_shadow_nxt = ld_val;
        end else if (w_en_acc) begin
            w_shadow_nxt = r_shadow + {{(W-1){1'b0}}, 1'b1};
        end
        case (r_state)
            IDLE: begin
                if (ld) begin
                    w_state_nxt = TRACK;
                end
            end
            TRACK: begin
                if (!ld && (cnt_out != r_shadow)) begin
                    w_state_nxt    = ERR;
                    w_mismatch_nxt = 1'b1;
                end
            end
            ERR: begin
                if (ld) begin
                    w_state_nxt    = TRACK;
                    w_mismatch_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shadow   <= '0;
            r_en_d     <= 1'b0;
            r_mismatch <= 1'b0;
            r_overflow <= 1'b0;
            r_wrap_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_shadow   <= w_shadow_nxt;
            r_en_d     <= w_en_acc;
            r_mismatch <= w_mismatch_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_wrap_inc) begin
                r_wrap_cnt <= r_wrap_cnt + {{(WCW-1){1'b0}}, 1'b1};
            end
        end
    end

    cnt_sample_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .din       (cnt_out),
        .pop_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .drop      (w_drop)
    );

    assign mismatch = r_mismatch;
    assign overflow = r_overflow;
    assign wrap_cnt = r_wrap_cnt;
    assign state    = r_state;

endmodule : cnt_out_checker
`default_nettype wire

// File: tb/tb_cnt_out_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cnt_out_checker
//  Brief    : Directed bench for cnt_out_checker with a behavioural upstream
//             counter driving cnt_out.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cnt_out_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld;
    logic [3:0] ld_val;
    logic       en;
    logic       out_ready;
    logic [3:0] cnt_out;
    logic       out_valid;
    logic [3:0] out_data;
    logic       mismatch;
    logic       overflow;
    logic [7:0] wrap_cnt;
    logic [1:0] state;

    logic       frc;
    logic [3:0] frc_val;
    logic [3:0] r_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Upstream counter model; frc overrides its output to inject a fault.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)  r_cnt <= 4'h0;
        else if (ld) r_cnt <= ld_val;
        else if (en) r_cnt <= r_cnt + 4'h1;
    end
    assign cnt_out = frc ? frc_val : r_cnt;

    cnt_out_checker #(.W(4), .DEPTH(4), .WCW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld        (ld),
        .ld_val    (ld_val),
        .en        (en),
        .cnt_out   (cnt_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mismatch  (mismatch),
        .overflow  (overflow),
        .wrap_cnt  (wrap_cnt),
        .state     (state)
    );

    typedef struct {
        logic       ld;
        logic [3:0] ldv;
        logic       en;
        logic       rdy;
        logic       frc;
        logic [3:0] fv;
        logic       vld;
        logic [3:0] dat;
        logic       mm;
        logic [1:0] st;
        logic [7:0] wrap;
    } vec_t;

    vec_t tbl [0:21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic [3:0] lv, input logic e, input logic r);
        ld = l; ld_val = lv; en = e; out_ready = r;
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [3:0] d, input logic ov);
        chk({nm, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({nm, ".data"},  {28'd0, out_data},  {28'd0, d});
        chk({nm, ".ovf"},   {31'd0, overflow},  {31'd0, ov});
    endtask

    initial begin
        rst_n = 1'b0; frc = 1'b0; frc_val = 4'h0;
        drive(1'b0, 4'h0, 1'b0, 1'b1);

        //              ld  ldv   en  rdy frc fv    vld dat   mm  st    wrap
        tbl[0]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 8'd0};
        tbl[1]  = '{1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd1, 8'd0};
        tbl[2]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd1, 8'd0};
        tbl[3]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h4, 1'b0, 2'd1, 8'd0};
        tbl[4]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h5, 1'b0, 2'd1, 8'd0};
        tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h6, 1'b0, 2'd1, 8'd0};
        tbl[6]  = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 2'd1, 8'd0};
        tbl[7]  = '{1'b1, 4'he, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 2'd1, 8'd0};
        tbl[8]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h6, 1'b0, 2'd1, 8'd0};
        tbl[9]  = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'hf, 1'b0, 2'd1, 8'd1};
        tbl[10] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd1, 8'd1};
        tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 2'd1, 8'd1};
        tbl[12] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h1, 1'b0, 2'd1, 8'd1};
        tbl[13] = '{1'b1, 4'hf, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h1, 1'b0, 2'd1, 8'd1};
        tbl[14] = '{1'b1, 4'hf, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h1, 1'b0, 2'd1, 8'd1};
        tbl[15] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h1, 1'b0, 2'd1, 8'd1};
        tbl[16] = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h1, 1'b0, 2'd1, 8'd1};
        tbl[17] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 4'h1, 1'b1, 2'd2, 8'd1};
        tbl[18] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 4'h1, 1'b1, 2'd2, 8'd1};
        tbl[19] = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h1, 1'b0, 2'd1, 8'd1};
        tbl[20] = '{1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 4'h1, 1'b0, 2'd1, 8'd1};
        tbl[21] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h1, 1'b0, 2'd1, 8'd1};

        #12;
        chk_out("reset", 1'b0, 4'h0, 1'b0);
        chk("reset.state", {30'd0, state}, 32'd0);
        chk("reset.mm", {31'd0, mismatch}, 32'd0);
        chk("reset.wrap", {24'd0, wrap_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].ld, tbl[i].ldv, tbl[i].en, tbl[i].rdy);
            frc = tbl[i].frc; frc_val = tbl[i].fv;
            tick;
            chk_out($sformatf("vec%0d", i), tbl[i].vld, tbl[i].dat, 1'b0);
            chk($sformatf("vec%0d.mm", i),   {31'd0, mismatch}, {31'd0, tbl[i].mm});
            chk($sformatf("vec%0d.st", i),   {30'd0, state},    {30'd0, tbl[i].st});
            chk($sformatf("vec%0d.wrap", i), {24'd0, wrap_cnt}, {24'd0, tbl[i].wrap});
        end
        frc = 1'b0;

        // Overflow: five increments into a 4-deep FIFO with no consumer.
        drive(1'b1, 4'h0, 1'b0, 1'b0); tick;
        drive(1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick;
        chk_out("ovf.fill", 1'b1, 4'h1, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0); tick;
        chk_out("ovf.drop", 1'b1, 4'h1, 1'b1);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            tick;
            chk_out($sformatf("ovf.drain%0d", i), 1'b1, 4'(i), 1'b1);
        end
        tick;
        chk_out("ovf.empty", 1'b0, 4'h4, 1'b1);

        // Asynchronous reset mid-cycle with three entries queued.
        drive(1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick;
        drive(1'b0, 4'h0, 1'b0, 1'b0); tick;
        chk_out("pre_rst", 1'b1, 4'h6, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 4'h0, 1'b0);
        chk("mid_rst.state", {30'd0, state}, 32'd0);
        chk("mid_rst.mm", {31'd0, mismatch}, 32'd0);
        chk("mid_rst.wrap", {24'd0, wrap_cnt}, 32'd0);
        #3 rst_n = 1'b1;

        // Full FIFO with simultaneous push and pop.
        drive(1'b1, 4'h0, 1'b0, 1'b0); tick;
        drive(1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick;
        chk_out("pp.full", 1'b1, 4'h1, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b1); tick;
        chk_out("pp.same_edge", 1'b1, 4'h2, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b0); tick;
        chk_out("pp.hold", 1'b1, 4'h2, 1'b0);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 3; i <= 5; i++) begin
            tick;
            chk_out($sformatf("pp.drain%0d", i), 1'b1, 4'(i), 1'b0);
        end
        tick;
        chk_out("pp.empty", 1'b0, 4'h5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cnt_out_checker
`default_nettype wire
